// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and parameter legality rule for the adder family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package pipelined_cla_adder_pkg;

  // Width of one carry-look-ahead group
  localparam int CLA_GRP = 4;

  // WIDTH must split into STAGES whole segments of 4-bit groups
  function automatic logic widths_legal(input int width, input int stages);
    if (stages < 1 || width < 1) begin
      return 1'b0;
    end
    return (width % (stages * CLA_GRP)) == 0;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_cla_block_4.sv
// 4-bit carry-look-ahead block: sum plus group propagate/generate.
// Latency: combinational.
// Backpressure: none, pure datapath.
module cla_block_4
  import pipelined_cla_adder_pkg::*;
(
  input  logic [CLA_GRP-1:0] a,
  input  logic [CLA_GRP-1:0] b,
  input  logic               ci,
  output logic [CLA_GRP-1:0] s,
  output logic               p,
  output logic               g
);

  logic [CLA_GRP-1:0] bp;
  logic [CLA_GRP-1:0] bg;
  logic [CLA_GRP-1:0] c;

  // Bit propagate/generate, fully expanded look-ahead carries and group terms
  always_comb begin
    bp   = a ^ b;
    bg   = a & b;
    c[0] = ci;
    c[1] = bg[0] | (bp[0] & ci);
    c[2] = bg[1] | (bp[1] & bg[0]) | (bp[1] & bp[0] & ci);
    c[3] = bg[2] | (bp[2] & bg[1]) | (bp[2] & bp[1] & bg[0])
         | (bp[2] & bp[1] & bp[0] & ci);
    s    = bp ^ c;
    p    = &bp;
    g    = bg[3] | (bp[3] & bg[2]) | (bp[3] & bp[2] & bg[1])
         | (bp[3] & bp[2] & bp[1] & bg[0]);
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined CLA adder/subtractor; one WIDTH/STAGES-bit segment resolved per stage.
// Latency: STAGES cycles from accepted beat to out_valid, one beat per cycle throughput.
// Backpressure: whole pipe freezes when out_valid && !out_ready; in_ready follows combinationally.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG_W = WIDTH / STAGES;
  localparam int NGRP  = SEG_W / CLA_GRP;

  if (!widths_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of STAGES*4 and STAGES >= 1");
  end

  logic             advance;
  logic [WIDTH-1:0] be;
  logic             ce;

  // The pipe moves as one unit whenever the output slot is free or being drained
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Subtraction is a + ~b + ~cin, so condition operands once at the entry
  assign be = b ^ {WIDTH{sub}};
  assign ce = cin ^ sub;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int DONE = (k + 1) * SEG_W;

    logic [SEG_W-1:0] seg_a;
    logic [SEG_W-1:0] seg_b;
    logic [SEG_W-1:0] seg_s;
    logic             seg_ci;
    logic [NGRP:0]    gc;
    logic             vld_d;
    logic             vld_q;
    logic [DONE-1:0]  sum_d;
    logic [DONE-1:0]  sum_q;
    logic             co_q;

    // Stage 0 reads the live operands; later stages read the skewed slices
    if (k == 0) begin : g_src
      assign seg_a  = a[SEG_W-1:0];
      assign seg_b  = be[SEG_W-1:0];
      assign seg_ci = ce;
      assign vld_d  = in_valid;
      assign sum_d  = seg_s;
    end else begin : g_src
      assign seg_a  = g_stage[k-1].g_up.opa_q[SEG_W-1:0];
      assign seg_b  = g_stage[k-1].g_up.opb_q[SEG_W-1:0];
      assign seg_ci = g_stage[k-1].co_q;
      assign vld_d  = g_stage[k-1].vld_q;
      assign sum_d  = {seg_s, g_stage[k-1].sum_q};
    end

    // Groups inside a segment are chained through their group P/G terms
    assign gc[0] = seg_ci;
    for (genvar j = 0; j < NGRP; j++) begin : g_grp
      logic grp_p;
      logic grp_g;

      cla_block_4 u_cla (
        .a  (seg_a[j*CLA_GRP +: CLA_GRP]),
        .b  (seg_b[j*CLA_GRP +: CLA_GRP]),
        .ci (gc[j]),
        .s  (seg_s[j*CLA_GRP +: CLA_GRP]),
        .p  (grp_p),
        .g  (grp_g)
      );

      assign gc[j+1] = grp_g | (grp_p & gc[j]);
    end

    // Finished low sum bits, segment carry and valid advance together or hold
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        sum_q <= '0;
        co_q  <= 1'b0;
      end else if (advance) begin
        vld_q <= vld_d;
        sum_q <= sum_d;
        co_q  <= gc[NGRP];
      end
    end

    if (k < STAGES - 1) begin : g_up
      localparam int UP_W = WIDTH - DONE;

      logic [UP_W-1:0] opa_d;
      logic [UP_W-1:0] opb_d;
      logic [UP_W-1:0] opa_q;
      logic [UP_W-1:0] opb_q;

      if (k == 0) begin : g_in
        assign opa_d = a[WIDTH-1:DONE];
        assign opb_d = be[WIDTH-1:DONE];
      end else begin : g_in
        assign opa_d = g_stage[k-1].g_up.opa_q[UP_W+SEG_W-1:SEG_W];
        assign opb_d = g_stage[k-1].g_up.opb_q[UP_W+SEG_W-1:SEG_W];
      end

      // Upper operand slices ride along until their segment's turn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          opa_q <= '0;
          opb_q <= '0;
        end else if (advance) begin
          opa_q <= opa_d;
          opb_q <= opb_d;
        end
      end
    end else begin : g_last
      logic c_msb;
      logic ovf_q;

      // Carry into the MSB recovered from its sum bit and conditioned operands
      assign c_msb = seg_a[SEG_W-1] ^ seg_b[SEG_W-1] ^ seg_s[SEG_W-1];

      // Signed overflow registered alongside the final slice
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= c_msb ^ gc[NGRP];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_q;
  assign s         = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].co_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: 8-bit/2-stage directed cases plus 32-bit/4-stage random stream.
// Latency: n/a.
// Backpressure: driven by the bench through out_ready.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  logic rst_n;

  logic       iv8, ir8, ov8, or8, cin8, sub8, co8, ovf8;
  logic [7:0] a8, b8, s8;

  logic        iv32, ir32, ov32, or32, cin32, sub32, co32, ovf32;
  logic [31:0] a32, b32, s32;

  int checks = 0;
  int errors = 0;

  pipelined_cla_adder #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .cin(cin8), .sub(sub8), .out_valid(ov8), .out_ready(or8), .s(s8),
    .cout(co8), .ovf(ovf8)
  );

  pipelined_cla_adder #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .cin(cin32), .sub(sub32), .out_valid(ov32), .out_ready(or32), .s(s32),
    .cout(co32), .ovf(ovf32)
  );

  always #5 clk = ~clk;

  // Reference {ovf, cout, s}; overflow from operand/result signs
  function automatic logic [33:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                        input logic ci, input logic sb);
    logic [31:0] ye;
    logic [32:0] full;
    logic        v;
    ye   = sb ? ~y : y;
    full = {1'b0, x} + {1'b0, ye} + {32'd0, ci ^ sb};
    v    = (x[31] == ye[31]) && (full[31] != x[31]);
    return {v, full[32], full[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv8 = 0; or8 = 0; a8 = 0; b8 = 0; cin8 = 0; sub8 = 0;
    iv32 = 0; or32 = 0; a32 = 0; b32 = 0; cin32 = 0; sub32 = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ov8, co8, ovf8, s8} !== 11'h0) begin
      errors++; $display("FAIL reset8_outputs: got %h expected 000", {ov8, co8, ovf8, s8});
    end
    checks++;
    if ({ov32, co32, ovf32, s32} !== 35'h0) begin
      errors++; $display("FAIL reset32_outputs: got %h expected 0", {ov32, co32, ovf32, s32});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (ir8 !== 1'b1 || ir32 !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b%b expected 11", ir8, ir32);
    end
  endtask

  task automatic test_latency();
    int cyc;
    logic [33:0] e32;
    // 8-bit: A5+5A+1
    a8 = 8'hA5; b8 = 8'h5A; cin8 = 1; sub8 = 0; iv8 = 1; or8 = 1;
    step();
    iv8 = 0; cyc = 1;
    #1;
    while (ov8 !== 1'b1 && cyc < 10) begin step(); cyc++; #1; end
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL latency8: got %0d cycles expected 2", cyc); end
    checks++;
    if ({ovf8, co8, s8} !== 10'h100) begin
      errors++; $display("FAIL add_a5_5a: got %h expected 100", {ovf8, co8, s8});
    end
    step();
    // 32-bit single beat
    a32 = 32'h89AB_CDEF; b32 = 32'h7654_3211; cin32 = 0; sub32 = 0; iv32 = 1; or32 = 1;
    e32 = ref32(a32, b32, cin32, sub32);
    step();
    iv32 = 0; cyc = 1;
    #1;
    while (ov32 !== 1'b1 && cyc < 12) begin step(); cyc++; #1; end
    checks++;
    if (cyc != 4) begin errors++; $display("FAIL latency32: got %0d cycles expected 4", cyc); end
    checks++;
    if ({ovf32, co32, s32} !== e32) begin
      errors++; $display("FAIL add32_carry_chain: got %h expected %h", {ovf32, co32, s32}, e32);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [9:0] q[$];
    logic [9:0] e;
    logic [7:0] av [2] = '{8'hFF, 8'h7F};
    logic [7:0] bv [2] = '{8'hFF, 8'h01};
    logic       cv [2] = '{1'b1, 1'b0};
    logic [9:0] ev [2] = '{10'h1FF, 10'h280};
    int idx = 0, got = 0, first = -1, last = -1;
    sub8 = 0; or8 = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      iv8 = (idx < 2);
      if (idx < 2) begin a8 = av[idx]; b8 = bv[idx]; cin8 = cv[idx]; end
      #1;
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: unexpected result %h", {ovf8, co8, s8});
        end else begin
          e = q.pop_front();
          if ({ovf8, co8, s8} !== e) begin
            errors++; $display("FAIL b2b_result: got %h expected %h", {ovf8, co8, s8}, e);
          end
        end
        if (first < 0) first = cyc;
        last = cyc; got++;
      end
      if (iv8 && ir8) begin q.push_back(ev[idx]); idx++; end
      step();
    end
    iv8 = 0;
    checks++;
    if (got != 2 || last != first + 1) begin
      errors++; $display("FAIL b2b_timing: got %0d results at %0d,%0d expected 2 consecutive", got, first, last);
    end
  endtask

  task automatic test_sub();
    logic [9:0] q[$];
    logic [9:0] e;
    logic [7:0] av [3] = '{8'h05, 8'h03, 8'h80};
    logic [7:0] bv [3] = '{8'h03, 8'h05, 8'h01};
    logic [9:0] ev [3] = '{10'h102, 10'h0FE, 10'h37F};
    int idx = 0, got = 0;
    sub8 = 1; cin8 = 0; or8 = 1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      iv8 = (idx < 3);
      if (idx < 3) begin a8 = av[idx]; b8 = bv[idx]; end
      #1;
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL sub_extra: unexpected result %h", {ovf8, co8, s8});
        end else begin
          e = q.pop_front();
          if ({ovf8, co8, s8} !== e) begin
            errors++; $display("FAIL sub_result: got %h expected %h", {ovf8, co8, s8}, e);
          end
        end
        got++;
      end
      if (iv8 && ir8) begin q.push_back(ev[idx]); idx++; end
      step();
    end
    iv8 = 0; sub8 = 0;
    checks++;
    if (got != 3) begin errors++; $display("FAIL sub_count: got %0d expected 3", got); end
  endtask

  task automatic test_backpressure();
    logic [9:0] q[$];
    logic [9:0] e;
    int idx = 0, got = 0;
    sub8 = 0; cin8 = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      iv8 = (idx < 4);
      a8 = 8'(idx + 1); b8 = 8'(idx + 1);
      or8 = (cyc >= 5);
      #1;
      if (cyc >= 2 && cyc < 5) begin
        checks++;
        if (ir8 !== 1'b0 || ov8 !== 1'b1 || s8 !== 8'h02) begin
          errors++; $display("FAIL stall_hold: got ir=%b ov=%b s=%h expected ir=0 ov=1 s=02", ir8, ov8, s8);
        end
      end
      if (ov8 && or8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected result %h", s8);
        end else begin
          e = q.pop_front();
          if ({ovf8, co8, s8} !== e) begin
            errors++; $display("FAIL bp_order: got %h expected %h", {ovf8, co8, s8}, e);
          end
        end
        got++;
      end
      if (iv8 && ir8) begin q.push_back({2'b00, 8'(2 * (idx + 1))}); idx++; end
      step();
    end
    iv8 = 0; or8 = 1;
    checks++;
    if (got != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, cyc;
    or8 = 0; sub8 = 0; cin8 = 0; b8 = 8'h01;
    for (int i = 0; i < 2; i++) begin
      iv8 = 1; a8 = 8'(8'h10 + i);
      step();
    end
    iv8 = 0;
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ov8 !== 1'b0 || s8 !== 8'h00) begin
      errors++; $display("FAIL midreset_clear: got ov=%b s=%h expected ov=0 s=00", ov8, s8);
    end
    step();
    step();
    rst_n = 1'b1; or8 = 1;
    #1;
    checks++;
    if (ir8 !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", ir8); end
    for (int i = 0; i < 8; i++) begin
      step();
      if (ov8 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_ghost: got %0d results expected 0", seen); end
    a8 = 8'h11; b8 = 8'h22; iv8 = 1;
    step();
    iv8 = 0; cyc = 1;
    #1;
    while (ov8 !== 1'b1 && cyc < 10) begin step(); cyc++; #1; end
    checks++;
    if (cyc != 2 || {ovf8, co8, s8} !== 10'h033) begin
      errors++; $display("FAIL midreset_first: got %0d cycles %h expected 2 cycles 033", cyc, {ovf8, co8, s8});
    end
    step();
  endtask

  task automatic test_random32();
    logic [33:0] q[$];
    logic [33:0] e, prev_o;
    logic pending = 1'b0, prev_stall = 1'b0;
    int sent = 0, got = 0, cyc = 0;
    iv32 = 0;
    while (got < 1000 && cyc < 20000) begin
      if (!pending) begin
        if (sent < 1000 && $urandom_range(3) != 0) begin
          iv32 = 1;
          a32 = $urandom;
          b32 = ($urandom_range(7) == 0) ? ~a32 : $urandom;
          cin32 = 1'($urandom_range(1));
          sub32 = 1'($urandom_range(1));
        end else begin
          iv32 = 0;
        end
      end
      or32 = ($urandom_range(3) != 0);
      #1;
      if (prev_stall) begin
        checks++;
        if (ov32 !== 1'b1 || {ovf32, co32, s32} !== prev_o) begin
          errors++; $display("FAIL rand_hold: got ov=%b %h expected ov=1 %h", ov32, {ovf32, co32, s32}, prev_o);
        end
      end
      if (ov32 && or32) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra: unexpected result %h", {ovf32, co32, s32});
        end else begin
          e = q.pop_front();
          if ({ovf32, co32, s32} !== e) begin
            errors++; $display("FAIL rand_result: got %h expected %h", {ovf32, co32, s32}, e);
          end
        end
        got++;
      end
      prev_stall = ov32 && !or32;
      prev_o     = {ovf32, co32, s32};
      if (iv32 && ir32) begin
        q.push_back(ref32(a32, b32, cin32, sub32));
        sent++;
        pending = 1'b0;
      end else begin
        pending = iv32;
      end
      step();
      cyc++;
    end
    iv32 = 0;
    checks++;
    if (got != 1000) begin errors++; $display("FAIL rand_count: got %0d expected 1000", got); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_sub();
    test_backpressure();
    test_reset_mid();
    test_random32();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
